// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell walks the operands LSB-first, WIDTH+1 edges from start to done.
// No backpressure: start is only accepted in IDLE/DONE, ignored during RUN; results hold until the next completion.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-2:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             ha1_s, ha1_c, ha2_c, s_bit, c_bit;
  logic             last, load;

  // Full adder built from two half-adder stages.
  assign ha1_s = op_a[0] ^ op_b[0];
  assign ha1_c = op_a[0] & op_b[0];
  assign s_bit = ha1_s ^ carry;
  assign ha2_c = ha1_s & carry;
  assign c_bit = ha1_c | ha2_c;

  assign last      = (count == CW'(WIDTH - 1));
  assign sreg_next = {s_bit, sreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      count <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      sreg  <= sreg_next[WIDTH-1:1];
      carry <= c_bit;
      count <= count + CW'(1);
      if (last) begin
        // carry still holds the carry into the MSB cell here
        sum  <= sreg_next;
        cout <= c_bit;
        ovf  <= c_bit ^ carry;
      end
    end
  end

endmodule
